// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter: FSM states and the
// kseg0/kseg1 address tags used by the virtual-to-physical mapping.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [2:0]  KSEG0_TAG = 3'b100;
  localparam logic [2:0]  KSEG1_TAG = 3'b101;
  localparam logic [31:0] PHYS_MASK = 32'h1FFF_FFFF;

  // True for unmapped kernel segments, which fold onto physical address zero.
  function automatic logic is_kseg01(input logic [2:0] tag);
    return (tag == KSEG0_TAG) || (tag == KSEG1_TAG);
  endfunction

endpackage

// File: rtl/kseg_map.sv
// Combinational kseg0/kseg1 mapping: clears the top three address bits of
// unmapped kernel-segment addresses, passes everything else through.
module kseg_map
  import sram_arb_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned MAP_EN = 1
) (
  input  logic [AW-1:0] vaddr,
  output logic [AW-1:0] paddr
);

  localparam logic [AW-1:0] Mask = (AW == 32) ? AW'(PHYS_MASK) : {3'b000, {(AW-3){1'b1}}};

  always_comb begin
    paddr = vaddr;
    if ((MAP_EN != 0) && is_kseg01(vaddr[AW-1:AW-3])) begin
      paddr = vaddr & Mask;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter merging N_CH core-side SRAM ports onto one req/ack
// memory port, with per-channel stall, completion pulse and timeout abort.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MAP_EN  = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        ch_en,
  input  logic [N_CH*DW/8-1:0]   ch_wen,
  input  logic [N_CH*AW-1:0]     ch_addr,
  input  logic [N_CH*DW-1:0]     ch_wdata,
  output logic [N_CH*DW-1:0]     ch_rdata,
  output logic [N_CH-1:0]        ch_stall,
  output logic [N_CH-1:0]        ch_done,
  output logic [N_CH-1:0]        ch_err,
  output logic                   mem_req,
  output logic [DW/8-1:0]        mem_wen,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ack,
  input  logic [DW-1:0]          mem_rdata
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned GW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  arb_state_e      state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   wen_d;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   wdata_d;
  logic [N_CH-1:0] rd_we;
  logic [GW-1:0]   grant;

  logic [N_CH*AW-1:0] paddr;

  for (genvar i = 0; i < N_CH; i++) begin : g_map
    kseg_map #(
      .AW     (AW),
      .MAP_EN (MAP_EN)
    ) u_kseg_map (
      .vaddr (ch_addr[i*AW +: AW]),
      .paddr (paddr[i*AW +: AW])
    );
  end

  // First requester strictly after ptr, wrapping; ptr itself is checked last.
  function automatic logic [GW-1:0] rr_pick(input logic [N_CH-1:0] req,
                                            input logic [GW-1:0]   ptr);
    logic [GW-1:0] sel;
    int            idx;
    sel = '0;
    for (int k = int'(N_CH); k >= 1; k--) begin
      idx = (int'(ptr) + k) % int'(N_CH);
      if (req[idx]) sel = idx[GW-1:0];
    end
    return sel;
  endfunction

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    wen_d   = mem_wen;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    rd_we   = '0;
    grant   = rr_pick(ch_en, rr_q);

    unique case (state_q)
      IDLE: begin
        if (|ch_en) begin
          gnt_d   = grant;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = REQ;
          for (int i = 0; i < int'(N_CH); i++) begin
            if (grant == GW'(i)) begin
              wen_d   = ch_wen[i*BW +: BW];
              addr_d  = paddr[i*AW +: AW];
              wdata_d = ch_wdata[i*DW +: DW];
            end
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = RESP;
          if (mem_wen == '0) begin
            for (int i = 0; i < int'(N_CH); i++) begin
              rd_we[i] = (gnt_q == GW'(i));
            end
          end
        end else begin
          if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
          // This cycle's miss brings the count to TIMEOUT: abort.
          if (cnt_q >= CW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        rr_d    = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      ch_done[i]  = (state_q == RESP) && (gnt_q == GW'(i));
      ch_err[i]   = ch_done[i] && err_q;
      ch_stall[i] = ch_en[i] && !ch_done[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rr_q      <= GW'(N_CH - 1);
      err_q     <= 1'b0;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_wen   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ch_rdata  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      mem_req   <= (state_d == REQ);
      mem_wen   <= wen_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      for (int i = 0; i < int'(N_CH); i++) begin
        if (rd_we[i]) ch_rdata[i*DW +: DW] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: a memory responder queues each transaction's planned
// response; an independent monitor predicts grants and completions.
module tb_sram_port_arbiter;

  localparam int N  = 2;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ch_en = '0;
  logic [31:0] req_addr[2];
  logic [31:0] req_wdata[2];
  logic [3:0]  req_wen[2];
  logic [7:0]  ch_wen;
  logic [63:0] ch_addr, ch_wdata, ch_rdata;
  logic [1:0]  ch_stall, ch_done, ch_err;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  // Second instance with mapping disabled.
  logic [1:0]  en2 = '0;
  logic [63:0] addr2 = '0;
  logic [63:0] rdata2;
  logic [1:0]  stall2, done2, err2;
  logic        req2;
  logic        ack2 = 1'b0;
  logic [3:0]  wen2;
  logic [31:0] maddr2, mwdata2;
  logic [31:0] mrdata2 = '0;

  assign ch_addr  = {req_addr[1], req_addr[0]};
  assign ch_wdata = {req_wdata[1], req_wdata[0]};
  assign ch_wen   = {req_wen[1], req_wen[0]};

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          d;
    logic [31:0] rdv;
  } resp_t;

  resp_t       comp_q[$];
  int          grant_log[$];
  int          force_d = -1;
  logic [31:0] force_rdata = '0;
  logic [31:0] shadow[2];

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .N_CH(2), .AW(32), .DW(32), .MAP_EN(1), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .ch_wen(ch_wen), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_stall(ch_stall), .ch_done(ch_done),
    .ch_err(ch_err), .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  sram_port_arbiter #(
    .N_CH(2), .AW(32), .DW(32), .MAP_EN(0), .TIMEOUT(TO)
  ) dut_nomap (
    .clk(clk), .rst(rst), .ch_en(en2), .ch_wen(8'h00), .ch_addr(addr2),
    .ch_wdata(64'h0), .ch_rdata(rdata2), .ch_stall(stall2), .ch_done(done2),
    .ch_err(err2), .mem_req(req2), .mem_wen(wen2), .mem_addr(maddr2),
    .mem_wdata(mwdata2), .mem_ack(ack2), .mem_rdata(mrdata2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_map(input logic [31:0] a);
    if (a[31:29] == 3'd4 || a[31:29] == 3'd5) return {3'b000, a[28:0]};
    return a;
  endfunction

  // Memory responder: picks a latency per transaction; d >= TO means never ack.
  initial begin : responder
    int          rk;
    int          rd;
    logic [31:0] rdv;
    logic        rprev;
    rk = 0; rd = 0; rdv = '0; rprev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ack = 1'b0;
        rprev   = 1'b0;
      end else if (mem_req) begin
        if (!rprev) begin
          rd  = (force_d >= 0) ? force_d : int'($urandom_range(0, 5));
          rdv = (force_d >= 0) ? force_rdata : $urandom;
          comp_q.push_back('{rd, rdv});
          rk = 0;
        end else begin
          rk++;
        end
        mem_ack   = (rk == rd);
        mem_rdata = (rk == rd) ? rdv : $urandom;
        rprev     = 1'b1;
      end else begin
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
        rprev     = 1'b0;
      end
    end
  end

  // Monitor: round-robin reference, completion and stall checks.
  initial begin : monitor
    logic       prev_req;
    logic [1:0] prev_en;
    int         last, cur, cyc, c;
    bit         cur_read, exp_done, err;
    logic [1:0] onehot;
    resp_t      e;
    prev_req = 1'b0; prev_en = '0; last = N - 1; cur = 0; cyc = 0; cur_read = 0;
    shadow[0] = '0; shadow[1] = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0; prev_en = '0; last = N - 1; cyc = 0;
        shadow[0] = '0; shadow[1] = '0;
        comp_q.delete();
      end else begin
        exp_done = prev_req && !mem_req;
        if (mem_req && !prev_req) begin
          chk("grant_has_requester", 64'(prev_en != 2'b00), 64'd1);
          cur = -1;
          for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (cur < 0 && prev_en[c]) cur = c;
          end
          if (cur < 0) cur = 0;
          chk("mem_addr", 64'(mem_addr), 64'(ref_map(req_addr[cur])));
          chk("mem_wen", 64'(mem_wen), 64'(req_wen[cur]));
          chk("mem_wdata", 64'(mem_wdata), 64'(req_wdata[cur]));
          cur_read = (req_wen[cur] == 4'h0);
          cyc = 0;
          grant_log.push_back(cur);
        end
        if (mem_req) cyc++;
        onehot = exp_done ? 2'(1 << cur) : 2'b00;
        chk("ch_done", 64'(ch_done), 64'(onehot));
        chk("ch_stall", 64'(ch_stall), 64'(ch_en & ~onehot));
        if (exp_done) begin
          chk("resp_queued", 64'(comp_q.size() != 0), 64'd1);
          if (comp_q.size() != 0) begin
            e   = comp_q.pop_front();
            err = (e.d >= TO);
            chk("ch_err", 64'(ch_err), err ? 64'(onehot) : 64'd0);
            chk("req_cycles", 64'(cyc), err ? 64'(TO) : 64'(e.d + 1));
            if (cur_read && !err) shadow[cur] = e.rdv;
            chk("ch_rdata", ch_rdata, {shadow[1], shadow[0]});
          end
          last = cur;
        end else begin
          chk("ch_err_quiet", 64'(ch_err), 64'd0);
        end
        prev_req = mem_req;
        prev_en  = ch_en;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the completion cycle.
  task automatic do_txn(input int i, input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d, output int lat);
    req_addr[i]  = a;
    req_wen[i]   = w;
    req_wdata[i] = d;
    ch_en[i]     = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!ch_done[i] && lat < 60);
    chk("txn_done", 64'(ch_done[i]), 64'd1);
    ch_en[i] = 1'b0;
  endtask

  task automatic rand_txn(input int i);
    int          l;
    logic [31:0] a;
    logic [3:0]  w;
    a = {3'($urandom_range(0, 7)), 29'($urandom)};
    w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
    do_txn(i, a, w, $urandom, l);
  endtask

  initial begin : main
    int          lat, l0, l1, n;
    logic [31:0] t6a[2];
    t6a[0] = 32'h9000_0000;
    t6a[1] = 32'hA000_0010;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_wdata[i] = '0; req_wen[i] = '0;
    end
    ch_en = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wen", 64'(mem_wen), 64'd0);
    chk("rst_ch_done", 64'(ch_done), 64'd0);
    chk("rst_ch_err", 64'(ch_err), 64'd0);
    chk("rst_ch_rdata", ch_rdata, 64'd0);
    chk("rst_ch_stall", 64'(ch_stall), 64'd3);
    ch_en = 2'b00;
    rst = 1'b0;
    step();

    // kseg1 read, ack on the fourth REQ cycle
    force_d = 3; force_rdata = 32'h1234_5678;
    do_txn(0, 32'hBFC0_0000, 4'h0, 32'h0, lat);
    chk("t1_latency", 64'(lat), 64'd5);
    chk("t1_rdata", 64'(ch_rdata[31:0]), 64'h1234_5678);
    step();

    // kseg0 write on ch1
    force_d = 0;
    do_txn(1, 32'h8000_0010, 4'b0011, 32'hA5A5_5A5A, lat);
    chk("t3_latency", 64'(lat), 64'd2);
    chk("t3_rdata1", 64'(ch_rdata[63:32]), 64'd0);
    step();

    // both channels contend
    grant_log.delete();
    fork
      begin
        do_txn(0, 32'h0000_0100, 4'h0, 32'h0, l0);
        do_txn(0, 32'h0000_0104, 4'h0, 32'h0, l0);
      end
      begin
        do_txn(1, 32'h0000_0200, 4'h0, 32'h0, l1);
        do_txn(1, 32'h0000_0204, 4'h0, 32'h0, l1);
      end
    join
    chk("t2_grant_count", 64'(grant_log.size()), 64'd4);
    n = grant_log.size();
    for (int i = 0; i < n && i < 4; i++) chk("t2_order", 64'(grant_log[i]), 64'(i % 2));
    step();

    // timeout abort
    force_d = 100;
    do_txn(0, 32'h0000_1000, 4'h0, 32'h0, lat);
    chk("t4_latency", 64'(lat), 64'd5);
    chk("t4_err", 64'(ch_err), 64'd1);
    step();
    chk("t4_idle", 64'(mem_req), 64'd0);
    force_d = 1;
    do_txn(1, 32'h0000_2000, 4'h0, 32'h0, lat);
    chk("t4_recover_latency", 64'(lat), 64'd3);
    step();

    // request withdrawn after grant still completes
    force_d = 2;
    req_addr[0] = 32'hA000_0040; req_wen[0] = 4'h0; req_wdata[0] = 32'h0;
    ch_en[0] = 1'b1;
    n = 0;
    while (!mem_req && n < 20) begin step(); n++; end
    ch_en[0] = 1'b0;
    n = 0;
    while (!ch_done[0] && n < 20) begin step(); n++; end
    chk("drop_done", 64'(ch_done[0]), 64'd1);
    step();

    // randomized contention
    force_d = -1;
    fork
      begin
        repeat (40) begin
          repeat ($urandom_range(0, 3)) step();
          rand_txn(0);
        end
      end
      begin
        repeat (40) begin
          repeat ($urandom_range(0, 3)) step();
          rand_txn(1);
        end
      end
    join
    step();

    // reset during REQ; last served is ch0 beforehand
    force_d = 0;
    do_txn(0, 32'h0000_3000, 4'h0, 32'h0, lat);
    step();
    force_d = 100;
    req_addr[0] = 32'h0000_3100; req_wen[0] = 4'h0;
    ch_en[0] = 1'b1;
    n = 0;
    while (!mem_req && n < 20) begin step(); n++; end
    step();
    #2 rst = 1'b1;
    #1;
    chk("t5_mem_req_drop", 64'(mem_req), 64'd0);
    chk("t5_rdata_clear", ch_rdata, 64'd0);
    ch_en = 2'b00;
    step();
    rst = 1'b0;
    step();
    force_d = 0;
    grant_log.delete();
    fork
      do_txn(0, 32'h0000_4000, 4'h0, 32'h0, l0);
      do_txn(1, 32'h0000_5000, 4'h0, 32'h0, l1);
    join
    chk("t5_first_grant", (grant_log.size() > 0) ? 64'(grant_log[0]) : 64'hFF, 64'd0);
    step();

    // mapping disabled: addresses pass through untouched
    for (int i = 0; i < 2; i++) begin
      addr2[31:0] = t6a[i];
      en2 = 2'b01;
      n = 0;
      while (!req2 && n < 20) begin step(); n++; end
      chk("t6_mem_addr", 64'(maddr2), 64'(t6a[i]));
      ack2 = 1'b1;
      mrdata2 = t6a[i] ^ 32'h0000_FFFF;
      step();
      ack2 = 1'b0;
      chk("t6_done", 64'(done2), 64'd1);
      chk("t6_rdata", 64'(rdata2[31:0]), 64'(t6a[i] ^ 32'h0000_FFFF));
      en2 = 2'b00;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
